// File: rtl/sprite_pixel_fetch_pkg.sv
// Shared image geometry, sprite layout, key colour and motion state encoding
// for the sprite pixel fetch block.
package sprite_pixel_fetch_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 17;
    localparam int IMG_W      = 320;
    localparam int IMG_H      = 240;
    localparam int SPR_W      = 64;
    localparam int SPR_H      = 32;
    localparam int SPR_FRAMES = 8;
    localparam int SPR_Y      = 104;
    localparam int SPR_BASE   = IMG_W * IMG_H;
    localparam int SPR_SIZE   = SPR_W * SPR_H;
    localparam int XPOS_W     = 9;
    localparam int ANIM_W     = 3;
    localparam int CNT_W      = 8;

    localparam logic [DATA_WIDTH-1:0] TRANSPARENT = 12'h0F0;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// Dual read-port image SRAM bus: the fetch block drives addresses (master),
// the SRAM returns one word per port one clock later (slave).
interface sprite_pixel_fetch_if;
    import sprite_pixel_fetch_pkg::*;

    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr1;
    logic [ADDR_WIDTH-1:0] sram_addr2;
    logic [DATA_WIDTH-1:0] sram_data1;
    logic [DATA_WIDTH-1:0] sram_data2;

    modport master (
        output sram_en, sram_we, sram_addr1, sram_addr2,
        input  sram_data1, sram_data2
    );

    modport slave (
        input  sram_en, sram_we, sram_addr1, sram_addr2,
        output sram_data1, sram_data2
    );

endinterface

// File: rtl/sprite_pixel_fetch_motion.sv
// Sprite bounce FSM plus animation frame sequencing; both advance only on
// frame_tick, divided by MOVE_DIV and ANIM_DIV respectively.
module sprite_pixel_fetch_motion
    import sprite_pixel_fetch_pkg::*;
#(
    parameter int ANIM_DIV = 4,
    parameter int MOVE_DIV = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    output logic [XPOS_W-1:0] x_pos,
    output dir_e              dir,
    output logic [ANIM_W-1:0] anim_idx
);

    localparam logic [CNT_W-1:0]  MOVE_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0]  ANIM_LAST = CNT_W'(ANIM_DIV - 1);
    localparam logic [XPOS_W-1:0] X_TURN_L  = XPOS_W'(IMG_W - SPR_W - 1);
    localparam logic [ANIM_W-1:0] LAST_FRM  = ANIM_W'(SPR_FRAMES - 1);

    logic [XPOS_W-1:0] x_pos_q;
    dir_e              dir_q;
    logic [ANIM_W-1:0] anim_idx_q;
    logic [CNT_W-1:0]  move_cnt_q;
    logic [CNT_W-1:0]  anim_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_pos_q    <= '0;
            dir_q      <= DIR_RIGHT;
            anim_idx_q <= '0;
            move_cnt_q <= '0;
            anim_cnt_q <= '0;
        end else if (frame_tick) begin
            if (move_cnt_q == MOVE_LAST) begin
                move_cnt_q <= '0;
                // Turn decisions look at x_pos before the step so the sprite
                // touches both edges (0 and IMG_W-SPR_W) exactly once.
                case (dir_q)
                    DIR_RIGHT: begin
                        x_pos_q <= x_pos_q + XPOS_W'(1);
                        if (x_pos_q == X_TURN_L) dir_q <= DIR_LEFT;
                    end
                    DIR_LEFT: begin
                        x_pos_q <= x_pos_q - XPOS_W'(1);
                        if (x_pos_q == XPOS_W'(1)) dir_q <= DIR_RIGHT;
                    end
                    default: dir_q <= DIR_RIGHT;
                endcase
            end else begin
                move_cnt_q <= move_cnt_q + CNT_W'(1);
            end

            if (anim_cnt_q == ANIM_LAST) begin
                anim_cnt_q <= '0;
                anim_idx_q <= (anim_idx_q == LAST_FRM) ? '0 : anim_idx_q + ANIM_W'(1);
            end else begin
                anim_cnt_q <= anim_cnt_q + CNT_W'(1);
            end
        end
    end

    assign x_pos    = x_pos_q;
    assign dir      = dir_q;
    assign anim_idx = anim_idx_q;

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Scan position -> SRAM addresses -> sprite/background composite, 3-clock pipeline.
// Optional macro SPRITE_MIRROR_EN: flip the sprite horizontally while moving left.
module sprite_pixel_fetch
    import sprite_pixel_fetch_pkg::*;
#(
    parameter int ANIM_DIV = 4,
    parameter int MOVE_DIV = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_tick,
    input  logic                  video_on,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    sprite_pixel_fetch_if.master  sram,
    output logic [DATA_WIDTH-1:0] rgb_out,
    output logic                  rgb_valid
);

    localparam logic [ADDR_WIDTH-1:0] IMG_W_A    = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] SPR_W_A    = ADDR_WIDTH'(SPR_W);
    localparam logic [ADDR_WIDTH-1:0] SPR_H_A    = ADDR_WIDTH'(SPR_H);
    localparam logic [ADDR_WIDTH-1:0] SPR_Y_A    = ADDR_WIDTH'(SPR_Y);
    localparam logic [ADDR_WIDTH-1:0] SPR_BASE_A = ADDR_WIDTH'(SPR_BASE);
    localparam logic [ADDR_WIDTH-1:0] SPR_SIZE_A = ADDR_WIDTH'(SPR_SIZE);

    logic [XPOS_W-1:0] x_pos;
    dir_e              dir;
    logic [ANIM_W-1:0] anim_idx;

    sprite_pixel_fetch_motion #(
        .ANIM_DIV (ANIM_DIV),
        .MOVE_DIV (MOVE_DIV)
    ) u_motion (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .x_pos      (x_pos),
        .dir        (dir),
        .anim_idx   (anim_idx)
    );

    // Screen is 2x upscaled, so the LSBs of the scan position only select the
    // duplicated screen pixel and carry no image information.
    logic unused_scan_lsb;
    assign unused_scan_lsb = ^{pixel_x[0], pixel_y[0], dir};

    logic [ADDR_WIDTH-1:0] ix_a, iy_a, xp_a, anim_a, col_raw, col;
    logic [ADDR_WIDTH-1:0] addr1_d, addr2_d;
    logic                  hit_d;

    always_comb begin
        ix_a    = ADDR_WIDTH'(pixel_x[9:1]);
        iy_a    = ADDR_WIDTH'(pixel_y[9:1]);
        xp_a    = ADDR_WIDTH'(x_pos);
        anim_a  = ADDR_WIDTH'(anim_idx);
        col_raw = ix_a - xp_a;
`ifdef SPRITE_MIRROR_EN
        col     = (dir == DIR_LEFT) ? (SPR_W_A - ADDR_WIDTH'(1) - col_raw) : col_raw;
`else
        col     = col_raw;
`endif
        hit_d   = (ix_a >= xp_a) && (ix_a < xp_a + SPR_W_A) &&
                  (iy_a >= SPR_Y_A) && (iy_a < SPR_Y_A + SPR_H_A);
        addr1_d = iy_a * IMG_W_A + ix_a;
        addr2_d = hit_d ? (SPR_BASE_A + anim_a * SPR_SIZE_A +
                           (iy_a - SPR_Y_A) * SPR_W_A + col)
                        : SPR_BASE_A;
    end

    logic [ADDR_WIDTH-1:0] addr1_q, addr2_q;
    logic                  hit_s0_q, von_s0_q, hit_s1_q, von_s1_q;
    logic [DATA_WIDTH-1:0] rgb_q;
    logic                  valid_q;

    // S0 registers addresses, S1 waits for the SRAM read, S2 composites.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr1_q  <= '0;
            addr2_q  <= '0;
            hit_s0_q <= 1'b0;
            von_s0_q <= 1'b0;
            hit_s1_q <= 1'b0;
            von_s1_q <= 1'b0;
            rgb_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            hit_s0_q <= hit_d;
            von_s0_q <= video_on;
            hit_s1_q <= hit_s0_q;
            von_s1_q <= von_s0_q;
            valid_q  <= von_s1_q;
            if (!von_s1_q)
                rgb_q <= '0;
            else if (hit_s1_q && (sram.sram_data2 != TRANSPARENT))
                rgb_q <= sram.sram_data2;
            else
                rgb_q <= sram.sram_data1;
        end
    end

    assign sram.sram_en    = 1'b1;
    assign sram.sram_we    = 1'b0;
    assign sram.sram_addr1 = addr1_q;
    assign sram.sram_addr2 = addr2_q;
    assign rgb_out         = rgb_q;
    assign rgb_valid       = valid_q;

endmodule
